// File: rtl/image_corner_dma_arbiter.sv
// Merges image line words and buffered corner words into one DMA stream per frame.
// Optional macro CORNER_HEADER_EN adds a {C0,00,count} header word before the corner section.
module image_corner_dma_arbiter #(
    parameter int IMG_WORDS_PER_LINE = 320,
    parameter int LINES_PER_FRAME    = 800,
    parameter int CORNER_FIFO_DEPTH  = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        new_frame,
    input  logic [31:0] line_data,
    input  logic        line_valid,
    output logic        line_ready,
    input  logic [31:0] corner_data,
    input  logic        corner_data_valid,
    output logic [31:0] dma_data,
    output logic        dma_valid,
    input  logic        dma_ready,
    output logic        dma_last,
    output logic        frame_done,
    output logic        corner_overflow,
    output logic        frame_error
);

    localparam int WW = (IMG_WORDS_PER_LINE > 1) ? $clog2(IMG_WORDS_PER_LINE) : 1;
    localparam int LW = (LINES_PER_FRAME > 1) ? $clog2(LINES_PER_FRAME) : 1;
    localparam int AW = $clog2(CORNER_FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LINE,
        S_CORNER_HDR,
        S_CORNER,
        S_DONE
    } state_t;

    state_t        state;
    logic [WW-1:0] word_cnt;
    logic [LW-1:0] line_cnt;
    logic [CW-1:0] corner_cnt;

    logic [31:0]   fifo_mem [CORNER_FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] fifo_count;

    logic out_load;
    logic line_accept;
    logic last_word;
    logic fifo_full;
    logic fifo_pop;
    logic fifo_wr;

    // The output register can take a new word when it is empty or being drained this cycle.
    assign out_load    = !dma_valid || dma_ready;
    assign line_ready  = (state == S_IDLE) || ((state == S_LINE) && out_load);
    assign line_accept = line_valid && line_ready;
    assign last_word   = (state == S_LINE)
                      && (word_cnt == WW'(IMG_WORDS_PER_LINE - 1))
                      && (line_cnt == LW'(LINES_PER_FRAME - 1));
    assign fifo_full   = (fifo_count == CW'(CORNER_FIFO_DEPTH));
    assign fifo_pop    = (state == S_CORNER) && out_load && (corner_cnt != '0);
    assign fifo_wr     = corner_data_valid && (!fifo_full || fifo_pop);

    // NOTE: storage array has no reset; only pointers and occupancy define FIFO contents.
    always_ff @(posedge clk) begin
        if (fifo_wr) begin
            fifo_mem[wr_ptr] <= corner_data;
        end
    end

    // NOTE: all state updates use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr          <= '0;
            rd_ptr          <= '0;
            fifo_count      <= '0;
            corner_overflow <= 1'b0;
        end else begin
            if (fifo_wr) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (fifo_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({fifo_wr, fifo_pop})
                2'b10:   fifo_count <= fifo_count + CW'(1);
                2'b01:   fifo_count <= fifo_count - CW'(1);
                default: fifo_count <= fifo_count;
            endcase
            if (corner_data_valid && !fifo_wr) begin
                corner_overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= S_IDLE;
            word_cnt    <= '0;
            line_cnt    <= '0;
            corner_cnt  <= '0;
            dma_data    <= '0;
            dma_valid   <= 1'b0;
            dma_last    <= 1'b0;
            frame_done  <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (out_load) begin
                dma_valid <= 1'b0;
                dma_last  <= 1'b0;
            end
            if (new_frame && (state != S_IDLE)) begin
                frame_error <= 1'b1;
            end

            case (state)
                S_IDLE: begin
                    if (new_frame) begin
                        word_cnt <= '0;
                        line_cnt <= '0;
                        state    <= S_LINE;
                    end
                end

                S_LINE: begin
                    if (line_accept) begin
                        dma_data  <= line_data;
                        dma_valid <= 1'b1;
                        dma_last  <= 1'b0;
                        if (word_cnt == WW'(IMG_WORDS_PER_LINE - 1)) begin
                            word_cnt <= '0;
                            line_cnt <= line_cnt + LW'(1);
                        end else begin
                            word_cnt <= word_cnt + WW'(1);
                        end
                        if (last_word) begin
                            // Writes landing this cycle are not yet counted and belong to the next frame.
                            corner_cnt <= fifo_count;
`ifdef CORNER_HEADER_EN
                            state <= S_CORNER_HDR;
`else
                            if (fifo_count == '0) begin
                                dma_last <= 1'b1;
                                state    <= S_DONE;
                            end else begin
                                state <= S_CORNER;
                            end
`endif
                        end
                    end
                end

`ifdef CORNER_HEADER_EN
                S_CORNER_HDR: begin
                    if (out_load) begin
                        dma_data  <= {8'hC0, 8'h00, 16'(corner_cnt)};
                        dma_valid <= 1'b1;
                        dma_last  <= (corner_cnt == '0);
                        state     <= (corner_cnt == '0) ? S_DONE : S_CORNER;
                    end
                end
`endif

                S_CORNER: begin
                    if (fifo_pop) begin
                        dma_data   <= fifo_mem[rd_ptr];
                        dma_valid  <= 1'b1;
                        dma_last   <= (corner_cnt == CW'(1));
                        corner_cnt <= corner_cnt - CW'(1);
                        if (corner_cnt == CW'(1)) begin
                            state <= S_DONE;
                        end
                    end
                end

                S_DONE: begin
                    // Leave only once the dma_last word has been handed over.
                    if (out_load) begin
                        frame_done <= 1'b1;
                        state      <= S_IDLE;
                    end
                end

                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: doc/image_corner_dma_arbiter.md
# image_corner_dma_arbiter

Merges the 32-bit line-word stream from `mipi_image_extractor` and the 32-bit corner-feature stream onto the single DMA stream. Per frame, the block forwards all image line words and then a corner section, with `dma_last` on the final word of the frame. Corner words arrive without backpressure, so the block buffers them in an internal FIFO. It sits between the image extractor and the DMA engine, and replaces direct wiring of `line_data` to DMA.

## Interface
- `IMG_WORDS_PER_LINE`, 320: 32-bit words per image line (1280 px / 4).
- `LINES_PER_FRAME`, 800: lines per frame.
- `CORNER_FIFO_DEPTH`, 64: corner FIFO entries; power of two, ≥4.

Ports:
- `clk` in 1: sole clock.
- `rst` in 1: synchronous, active-high reset.
- `new_frame` in 1: one-cycle frame-start pulse from the extractor.
- `line_data` in 32: image word.
- `line_valid` in 1: `line_data` valid.
- `line_ready` out 1: image word accepted when `line_valid && line_ready`.
- `corner_data` in 32: corner word.
- `corner_data_valid` in 1: write strobe; no backpressure.
- `dma_data` out 32: output word.
- `dma_valid` out 1: output valid.
- `dma_ready` in 1: DMA accepts when `dma_valid && dma_ready`.
- `dma_last` out 1: last word of frame, qualified by `dma_valid`.
- `frame_done` out 1: one-cycle pulse after the `dma_last` handshake.
- `corner_overflow` out 1: sticky flag, corner word dropped because FIFO was full.
- `frame_error` out 1: sticky flag, `new_frame` arrived outside IDLE.

## Operation
- States: IDLE, LINE, CORNER_HDR (only with macro), CORNER, DONE.
- **IDLE**
  - `line_ready`=1; accepted line words are discarded.
  - On `new_frame`: clear line and word counters, go to LINE.
- **LINE**
  - Forward line words.
  - Word counter wraps at `IMG_WORDS_PER_LINE`-1 and increments the line counter.
  - After word `IMG_WORDS_PER_LINE`-1 of line `LINES_PER_FRAME`-1 is accepted:
    - Snapshot the FIFO occupancy into `corner_cnt`.
    - With the macro, go to CORNER_HDR.
    - Without it, go to CORNER if `corner_cnt`≠0, else to DONE. In the `corner_cnt`=0 case, that final image word carries `dma_last`=1.
- **CORNER_HDR**
  - Emit one word `{8'hC0, 8'h00, 16'(corner_cnt)}`.
  - `dma_last`=1 on this word if `corner_cnt`=0; then go to DONE.
  - Otherwise go to CORNER.
- **CORNER**
  - Pop and emit exactly `corner_cnt` words; `dma_last` on the final one; then go to DONE.
  - Corner words written after the snapshot stay in the FIFO for the next frame.
- **DONE**
  - Pulse `frame_done` for one cycle, go to IDLE.
- Outside IDLE and LINE, `line_ready`=0.
- FIFO write:
  - Accepted whenever not full.
  - A write in the same cycle as a pop while full is accepted.
  - A write while full with no pop is dropped and sets `corner_overflow`.
- `new_frame` in any state other than IDLE:
  - Sets `frame_error`.
  - Is otherwise ignored; the current frame completes normally.
- Sticky flags clear only on `rst`.

## Timing
- The output stage is a single register.
  - A new word loads when `!dma_valid || dma_ready`.
  - `line_ready` in LINE equals that load condition.
  - Latency from input accept to `dma_valid`: 1 cycle.
- While `dma_valid && !dma_ready`, `dma_data` and `dma_last` hold stable.
- A FIFO write becomes visible to occupancy and pop on the next cycle.
- The occupancy snapshot is taken in the same cycle as the last image-word accept.
- `frame_done` asserts the cycle after the `dma_last` handshake.
- Reset values:
  - State: IDLE.
  - `dma_valid`, `dma_last`, `frame_done`, `corner_overflow`, `frame_error`: 0.
  - `dma_data`: 0.
  - `line_ready`: 1.
  - FIFO: empty.
- Reset mid-frame:
  - The next cycle is IDLE with empty output and FIFO.
  - An in-flight word is discarded; no `dma_last` is emitted.

## Configuration
- `CORNER_HEADER_EN` defined:
  - The CORNER_HDR word precedes the corner section every frame, including when `corner_cnt`=0.
- `CORNER_HEADER_EN` undefined:
  - No header word is emitted.
  - Corner words follow the image words directly.
  - With no corners, `dma_last` sits on the last image word.

## Test plan
- **Frame with corners**
  - `LINES_PER_FRAME`=2, `IMG_WORDS_PER_LINE`=4, `dma_ready`=1.
  - `new_frame`, then 8 line words 0..7; 3 corner words written mid-frame.
  - Required: DMA emits 0..7, then `C0000003` (macro on), then the 3 corner words in order; `dma_last` on the 3rd corner word; `frame_done` 1 cycle later.
- **No corners**
  - Same setup, no corner writes.
  - Macro on: `C0000000` with `dma_last`. Macro off: `dma_last` on word 7.
- **Backpressure**
  - Toggle `dma_ready` 1/0 each cycle.
  - Required: no duplicated or dropped words, `dma_data` stable while stalled, `line_ready`=0 when stalled.
- **Overflow**
  - `CORNER_FIFO_DEPTH`=4, 6 corner writes before the frame ends.
  - Required: `corner_overflow`=1, header count 4, first 4 corner words emitted.
- **Protocol abuse**
  - Line words before `new_frame`: discarded.
  - `new_frame` mid-LINE: `frame_error`=1 and the frame still completes.
  - `rst` mid-CORNER: next cycle `dma_valid`=0, state IDLE, sticky flags 0.
